pa_fpu_ex_ctrl: RTL and testbench

Sequencing controller for the single-precision FPU execute pipeline. It accepts one issued FP instruction at a time from the IDU and drives the EX1 qualifiers consumed by the FPU datapath. It launches and kills the iterative divide/sqrt unit (FDSU), times the fixed-latency multiply-add unit (FMAU), and presents a single write-back handshake to the retire unit. It also generates the post-reset warm-up window that flushes datapath pipeline registers.

---
 rtl/pa_fpu_ex_ctrl.sv | 164 ++++++++++++++++
 tb/tb_pa_fpu_ex_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pa_fpu_ex_ctrl.sv
// Sequencing controller for the single-precision FPU execute stage: warm-up
// window, FDSU launch/kill, fixed-latency FMAU timing and one write-back port.
module pa_fpu_ex_ctrl #(
    parameter int WARM_CYCLES = 4,
    parameter int MAU_LAT     = 3
) (
    input  logic       forever_cpuclk,
    input  logic       cpurst,
    input  logic       idu_fpu_ex1_inst_vld,
    output logic       fpu_idu_ex1_ready,
    input  logic [2:0] idu_fpu_ex1_eu_sel,
    input  logic [4:0] idu_fpu_ex1_dst_reg,
    input  logic       fpu_ex1_special_vld,
    input  logic       fdsu_fpu_busy,
    input  logic       fdsu_fpu_done,
    input  logic       rtu_fpu_flush,
    input  logic       rtu_fpu_wb_ready,
    output logic       ctrl_xx_ex1_inst_vld,
    output logic       ctrl_xx_ex1_stall,
    output logic       ctrl_xx_ex1_warm_up,
    output logic [2:0] ctrl_ex1_eu_sel,
    output logic       ctrl_ex1_gateclk_vld,
    output logic       fpu_fdsu_start,
    output logic       fpu_fdsu_kill,
    output logic       fpu_rtu_wb_vld,
    output logic [4:0] fpu_rtu_wb_reg,
    output logic       fpu_rtu_wb_sel
);
    localparam int WARM_W = $clog2(WARM_CYCLES + 1);
    localparam int MAU_W  = (MAU_LAT > 1) ? $clog2(MAU_LAT) : 1;
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARM_CYCLES - 1);
    localparam logic [MAU_W-1:0]  MAU_LOAD  = MAU_W'(MAU_LAT - 1);

    typedef enum logic [2:0] {
        S_WARM, S_IDLE, S_EX1, S_WAIT_MAU, S_WAIT_FDSU, S_WB
    } state_t;

    state_t            state_reg, state_next;
    logic [WARM_W-1:0] warm_cnt_reg, warm_cnt_next;
    logic [MAU_W-1:0]  mau_cnt_reg, mau_cnt_next;
    logic [2:0]        eu_sel_reg, eu_sel_next;
    logic [4:0]        wb_dst_reg, wb_dst_next;
    logic              wb_sel_reg, wb_sel_next;
    logic [2:0]        sel_raw, sel_onehot;

    // An empty unit select defaults to the single-cycle unit; highest bit wins.
    assign sel_raw = (idu_fpu_ex1_eu_sel == 3'b000) ? 3'b001 : idu_fpu_ex1_eu_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sel_pri
            if (gi == 2) begin : g_top
                assign sel_onehot[gi] = sel_raw[gi];
            end else begin : g_low
                assign sel_onehot[gi] = sel_raw[gi] && !(|sel_raw[2:gi+1]);
            end
        end
    endgenerate

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            state_reg    <= S_WARM;
            warm_cnt_reg <= '0;
            mau_cnt_reg  <= '0;
            eu_sel_reg   <= '0;
            wb_dst_reg   <= '0;
            wb_sel_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            warm_cnt_reg <= warm_cnt_next;
            mau_cnt_reg  <= mau_cnt_next;
            eu_sel_reg   <= eu_sel_next;
            wb_dst_reg   <= wb_dst_next;
            wb_sel_reg   <= wb_sel_next;
        end
    end

    always_comb begin
        state_next           = state_reg;
        warm_cnt_next        = warm_cnt_reg;
        mau_cnt_next         = mau_cnt_reg;
        eu_sel_next          = eu_sel_reg;
        wb_dst_next          = wb_dst_reg;
        wb_sel_next          = wb_sel_reg;
        fpu_idu_ex1_ready    = 1'b0;
        ctrl_xx_ex1_inst_vld = 1'b0;
        ctrl_xx_ex1_stall    = 1'b0;
        ctrl_xx_ex1_warm_up  = 1'b0;
        ctrl_ex1_gateclk_vld = 1'b0;
        fpu_fdsu_start       = 1'b0;
        fpu_fdsu_kill        = 1'b0;
        fpu_rtu_wb_vld       = 1'b0;

        case (state_reg)
            S_WARM: begin
                ctrl_xx_ex1_warm_up = 1'b1;
                if (warm_cnt_reg == WARM_LAST) begin
                    state_next = S_IDLE;
                end else begin
                    warm_cnt_next = warm_cnt_reg + WARM_W'(1);
                end
            end
            S_IDLE: begin
                fpu_idu_ex1_ready = !rtu_fpu_flush;
                if (idu_fpu_ex1_inst_vld && !rtu_fpu_flush) begin
                    eu_sel_next = sel_onehot;
                    wb_dst_next = idu_fpu_ex1_dst_reg;
                    state_next  = S_EX1;
                end
            end
            S_EX1: begin
                ctrl_xx_ex1_inst_vld = 1'b1;
                ctrl_ex1_gateclk_vld = 1'b1;
                if (eu_sel_reg[2] && fdsu_fpu_busy) begin
                    ctrl_xx_ex1_stall = 1'b1;
                end else if (fpu_ex1_special_vld) begin
                    wb_sel_next = 1'b0;
                    state_next  = S_WB;
                end else if (eu_sel_reg[0]) begin
                    wb_sel_next = 1'b1;
                    state_next  = S_WB;
                end else if (eu_sel_reg[1]) begin
                    mau_cnt_next = MAU_LOAD;
                    state_next   = S_WAIT_MAU;
                end else begin
                    fpu_fdsu_start = !rtu_fpu_flush;
                    state_next     = S_WAIT_FDSU;
                end
            end
            S_WAIT_MAU: begin
                if (mau_cnt_reg == '0) begin
                    wb_sel_next = 1'b1;
                    state_next  = S_WB;
                end else begin
                    mau_cnt_next = mau_cnt_reg - MAU_W'(1);
                end
            end
            S_WAIT_FDSU: begin
                // A result landing in the flush cycle needs no abort.
                fpu_fdsu_kill = rtu_fpu_flush && !fdsu_fpu_done;
                if (fdsu_fpu_done) begin
                    wb_sel_next = 1'b1;
                    state_next  = S_WB;
                end
            end
            S_WB: begin
                fpu_rtu_wb_vld = !rtu_fpu_flush;
                if (rtu_fpu_wb_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase

        if (rtu_fpu_flush && state_reg != S_WARM) begin
            state_next = S_IDLE;
        end
    end

    assign ctrl_ex1_eu_sel = eu_sel_reg;
    assign fpu_rtu_wb_reg  = wb_dst_reg;
    assign fpu_rtu_wb_sel  = wb_sel_reg;

endmodule

// File: tb/tb_pa_fpu_ex_ctrl.sv
// Bench for pa_fpu_ex_ctrl: each transaction is expanded into a per-cycle
// expectation table from the issue/latency/flush timing rules, then replayed.
module tb_pa_fpu_ex_ctrl;
    localparam int WARM_CYCLES = 4;
    localparam int MAU_LAT     = 3;

    logic       forever_cpuclk;
    logic       cpurst;
    logic       idu_fpu_ex1_inst_vld;
    logic       fpu_idu_ex1_ready;
    logic [2:0] idu_fpu_ex1_eu_sel;
    logic [4:0] idu_fpu_ex1_dst_reg;
    logic       fpu_ex1_special_vld;
    logic       fdsu_fpu_busy;
    logic       fdsu_fpu_done;
    logic       rtu_fpu_flush;
    logic       rtu_fpu_wb_ready;
    logic       ctrl_xx_ex1_inst_vld;
    logic       ctrl_xx_ex1_stall;
    logic       ctrl_xx_ex1_warm_up;
    logic [2:0] ctrl_ex1_eu_sel;
    logic       ctrl_ex1_gateclk_vld;
    logic       fpu_fdsu_start;
    logic       fpu_fdsu_kill;
    logic       fpu_rtu_wb_vld;
    logic [4:0] fpu_rtu_wb_reg;
    logic       fpu_rtu_wb_sel;

    pa_fpu_ex_ctrl #(.WARM_CYCLES(WARM_CYCLES), .MAU_LAT(MAU_LAT)) dut (
        .forever_cpuclk       (forever_cpuclk),
        .cpurst               (cpurst),
        .idu_fpu_ex1_inst_vld (idu_fpu_ex1_inst_vld),
        .fpu_idu_ex1_ready    (fpu_idu_ex1_ready),
        .idu_fpu_ex1_eu_sel   (idu_fpu_ex1_eu_sel),
        .idu_fpu_ex1_dst_reg  (idu_fpu_ex1_dst_reg),
        .fpu_ex1_special_vld  (fpu_ex1_special_vld),
        .fdsu_fpu_busy        (fdsu_fpu_busy),
        .fdsu_fpu_done        (fdsu_fpu_done),
        .rtu_fpu_flush        (rtu_fpu_flush),
        .rtu_fpu_wb_ready     (rtu_fpu_wb_ready),
        .ctrl_xx_ex1_inst_vld (ctrl_xx_ex1_inst_vld),
        .ctrl_xx_ex1_stall    (ctrl_xx_ex1_stall),
        .ctrl_xx_ex1_warm_up  (ctrl_xx_ex1_warm_up),
        .ctrl_ex1_eu_sel      (ctrl_ex1_eu_sel),
        .ctrl_ex1_gateclk_vld (ctrl_ex1_gateclk_vld),
        .fpu_fdsu_start       (fpu_fdsu_start),
        .fpu_fdsu_kill        (fpu_fdsu_kill),
        .fpu_rtu_wb_vld       (fpu_rtu_wb_vld),
        .fpu_rtu_wb_reg       (fpu_rtu_wb_reg),
        .fpu_rtu_wb_sel       (fpu_rtu_wb_sel)
    );

    initial forever_cpuclk = 1'b0;
    always #5 forever_cpuclk = ~forever_cpuclk;

    int cyc = 0;
    always @(posedge forever_cpuclk) cyc <= cyc + 1;

    typedef struct {
        logic       rst, vld, flush, busy, done, special, wb_ready;
        logic [2:0] sel;
        logic [4:0] dst;
        logic       e_ready, e_inst_vld, e_stall, e_warm, e_start, e_kill, e_wb_vld;
        logic       chk_wb, e_wb_sel, chk_sel;
        logic [4:0] e_wb_reg;
        logic [2:0] e_eu_sel;
    } cyc_t;

    cyc_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   txn_id   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d txn %0d: got %0h expected %0h", tag, cyc, txn_id, got, exp);
        end
    endtask

    // Unconstrained inputs are random junk the controller must ignore.
    function automatic cyc_t rand_rec();
        cyc_t c;
        c = '{default: 0};
        c.sel      = 3'($urandom);
        c.dst      = 5'($urandom);
        c.busy     = 1'($urandom);
        c.done     = 1'($urandom);
        c.special  = 1'($urandom);
        c.wb_ready = 1'($urandom);
        return c;
    endfunction

    task automatic push_idle();
        cyc_t c;
        c = rand_rec();
        c.e_ready = 1'b1;
        q.push_back(c);
    endtask

    task automatic push_reset_and_warm();
        cyc_t c;
        c = rand_rec();
        c.rst = 1'b1; c.e_warm = 1'b1; c.chk_wb = 1'b1; c.chk_sel = 1'b1;
        q.push_back(c);
        for (int i = 0; i < WARM_CYCLES; i++) begin
            c = rand_rec();
            c.vld = 1'($urandom); c.flush = 1'($urandom);
            c.e_warm = 1'b1; c.chk_wb = 1'b1; c.chk_sel = 1'b1;
            q.push_back(c);
        end
        push_idle();
    endtask

    // flush_ph: 0 idle, 1 last EX1 cycle, 2 wait, 3 write-back, 4 reset in wait/WB, else none.
    task automatic gen_txn(input logic [2:0] raw, input logic [4:0] dst, input bit special,
                           input int busy_n, input int done_n, input int stall_n,
                           input int flush_ph, input int fidx);
        cyc_t c;
        logic [2:0] res;
        bit is_fdsu, is_mau, direct_wb;
        int n_ex1, n_wait;
        res       = raw[2] ? 3'b100 : (raw[1] ? 3'b010 : 3'b001);
        is_fdsu   = res[2];
        is_mau    = res[1];
        direct_wb = special || res[0];
        txn_id++;
        $display("txn %0d: eu_sel=%b dst=%0d special=%0d busy=%0d done_at=%0d wb_stall=%0d event=%0d",
                 txn_id, raw, dst, special, busy_n, done_n, stall_n, flush_ph);

        push_idle();
        if (flush_ph == 0) begin
            c = rand_rec(); c.vld = 1'b1; c.flush = 1'b1;
            q.push_back(c);
        end
        c = rand_rec(); c.vld = 1'b1; c.sel = raw; c.dst = dst; c.e_ready = 1'b1;
        q.push_back(c);

        n_ex1 = is_fdsu ? busy_n + 1 : 1;
        for (int i = 0; i < n_ex1; i++) begin
            c = rand_rec();
            c.e_inst_vld = 1'b1; c.chk_sel = 1'b1; c.e_eu_sel = res;
            if (is_fdsu) c.busy = (i < busy_n);
            if (i == n_ex1 - 1) begin
                c.special = special;
                c.flush   = (flush_ph == 1);
                c.e_start = is_fdsu && !special && !c.flush;
            end else begin
                c.e_stall = 1'b1;
            end
            q.push_back(c);
        end
        if (flush_ph == 1) begin
            push_idle();
            return;
        end

        if (!direct_wb) begin
            n_wait = is_mau ? MAU_LAT : done_n;
            for (int i = 0; i < n_wait; i++) begin
                c = rand_rec();
                c.chk_sel = 1'b1; c.e_eu_sel = res;
                if (is_fdsu) c.done = (i == n_wait - 1);
                if (i == fidx % n_wait && flush_ph == 4) begin
                    push_reset_and_warm();
                    return;
                end
                if (i == fidx % n_wait && flush_ph == 2) begin
                    c.flush  = 1'b1;
                    c.e_kill = is_fdsu && !c.done;
                    q.push_back(c);
                    push_idle();
                    return;
                end
                q.push_back(c);
            end
        end

        for (int i = 0; i <= stall_n; i++) begin
            c = rand_rec();
            c.wb_ready = (i == stall_n);
            c.chk_wb = 1'b1; c.e_wb_reg = dst; c.e_wb_sel = !special;
            c.chk_sel = 1'b1; c.e_eu_sel = res;
            c.e_wb_vld = 1'b1;
            if (i == fidx % (stall_n + 1) && flush_ph == 4) begin
                push_reset_and_warm();
                return;
            end
            if (i == fidx % (stall_n + 1) && flush_ph == 3) begin
                c.flush = 1'b1; c.e_wb_vld = 1'b0;
                q.push_back(c);
                push_idle();
                return;
            end
            q.push_back(c);
        end
        push_idle();
    endtask

    task automatic play();
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            cpurst               = c.rst;
            idu_fpu_ex1_inst_vld = c.vld;
            idu_fpu_ex1_eu_sel   = c.sel;
            idu_fpu_ex1_dst_reg  = c.dst;
            fpu_ex1_special_vld  = c.special;
            fdsu_fpu_busy        = c.busy;
            fdsu_fpu_done        = c.done;
            rtu_fpu_flush        = c.flush;
            rtu_fpu_wb_ready     = c.wb_ready;
            @(negedge forever_cpuclk);
            check_eq("ready",    32'(fpu_idu_ex1_ready),    32'(c.e_ready));
            check_eq("inst_vld", 32'(ctrl_xx_ex1_inst_vld), 32'(c.e_inst_vld));
            check_eq("gateclk",  32'(ctrl_ex1_gateclk_vld), 32'(c.e_inst_vld));
            check_eq("stall",    32'(ctrl_xx_ex1_stall),    32'(c.e_stall));
            check_eq("warm_up",  32'(ctrl_xx_ex1_warm_up),  32'(c.e_warm));
            check_eq("start",    32'(fpu_fdsu_start),       32'(c.e_start));
            check_eq("kill",     32'(fpu_fdsu_kill),        32'(c.e_kill));
            check_eq("wb_vld",   32'(fpu_rtu_wb_vld),       32'(c.e_wb_vld));
            if (c.chk_wb) begin
                check_eq("wb_reg", 32'(fpu_rtu_wb_reg), 32'(c.e_wb_reg));
                check_eq("wb_sel", 32'(fpu_rtu_wb_sel), 32'(c.e_wb_sel));
            end
            if (c.chk_sel) begin
                check_eq("eu_sel", 32'(ctrl_ex1_eu_sel), 32'(c.e_eu_sel));
            end
            @(posedge forever_cpuclk);
            #1;
        end
    endtask

    initial begin
        cpurst = 1'b1;
        idu_fpu_ex1_inst_vld = 1'b0; idu_fpu_ex1_eu_sel = 3'b000; idu_fpu_ex1_dst_reg = 5'd0;
        fpu_ex1_special_vld = 1'b0; fdsu_fpu_busy = 1'b0; fdsu_fpu_done = 1'b0;
        rtu_fpu_flush = 1'b0; rtu_fpu_wb_ready = 1'b0;
        repeat (2) @(posedge forever_cpuclk);
        #1;
        push_reset_and_warm();
        play();

        gen_txn(3'b001,  5, 1'b0, 0, 1, 0, 9, 0); play();
        gen_txn(3'b010,  9, 1'b0, 0, 1, 3, 9, 0); play();
        gen_txn(3'b100, 12, 1'b1, 0, 1, 0, 9, 0); play();
        gen_txn(3'b100,  3, 1'b0, 0, 3, 0, 2, 0); play();
        gen_txn(3'b100,  7, 1'b0, 2, 2, 1, 9, 0); play();
        gen_txn(3'b000, 21, 1'b0, 0, 1, 0, 0, 0); play();
        gen_txn(3'b110, 30, 1'b0, 1, 2, 0, 2, 1); play();
        gen_txn(3'b011, 17, 1'b0, 0, 1, 0, 3, 0); play();
        gen_txn(3'b010,  4, 1'b0, 0, 1, 0, 4, 1); play();
        gen_txn(3'b101,  8, 1'b0, 0, 2, 0, 1, 0); play();

        for (int n = 0; n < 150; n++) begin
            gen_txn(3'($urandom), 5'($urandom), ($urandom_range(0, 3) == 0),
                    int'($urandom_range(0, 2)), int'($urandom_range(1, 4)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 9)),
                    int'($urandom_range(0, 7)));
            play();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
